higher_or_lower_game_ctrl: RTL
==============================

Name: higher_or_lower_game_ctrl

Overview:
Parametrised successor to the single-miss higher/lower game FSM, adding:
- configurable number width, score width and multi-life play;
- a selectable tie policy;
- a persistent high score;
- internal button edge detection;
- a request/valid handshake to an external random-number source.

It sits between the debounced board buttons and the VGA renderer and RGB LED, and exposes all game state for display.

Parameters:
NUM_W, 8, width of drawn numbers
SCORE_W, 8, width of score and high score; score saturates at 2^SCORE_W-1
LIVES, 3, misses allowed per game (>=1)
TIE_MODE, 0, tie policy: 0 = tie is a miss, 1 = tie is correct, 2 = tie is neutral
LIV_W, $clog2(LIVES+1), width of lives counter (derived)

Ports:
clk  in  1  system clock
reset  in  1  reset
higher_btn  in  1  debounced level, "higher" guess
lower_btn  in  1  debounced level, "lower" guess
confirm_btn  in  1  debounced level, start/restart
rnd_data  in  NUM_W  random value from source
rnd_valid  in  1  rnd_data valid
rnd_req  out  1  request for a random value
state  out  3  0=IDLE 1=DRAW_FIRST 2=GUESS 3=DRAW_NEXT 4=CHECK 5=RESULT
cur_num  out  NUM_W  number currently shown
next_num  out  NUM_W  most recently drawn comparison number
score  out  SCORE_W  current streak score
high_score  out  SCORE_W  best score since reset
lives_left  out  LIV_W  remaining lives
last_correct  out  1  result of the most recent CHECK
new_high  out  1  one-cycle pulse when high_score is updated
rgb_led  out  3  {R,G,B}

Behaviour:
- Reset is asynchronous, active-high, on clk.
  - Reset values: state=IDLE, rgb_led=000, cur_num=0, next_num=0, score=0, high_score=0, lives_left=LIVES, last_correct=0, new_high=0, rnd_req=0.
  - Button history registers reset to 0.
- Reset mid-operation aborts the game and clears high_score.
- Edge detection:
  - Each button has a registered previous value; an action fires only on a rise (btn & ~btn_q).
  - A held button produces exactly one action.
  - A button already high when reset releases produces a rise on the first cycle.
- Handshake:
  - rnd_req is high combinationally in DRAW_FIRST and DRAW_NEXT only.
  - A transfer occurs in any cycle where rnd_req && rnd_valid; rnd_valid while rnd_req=0 is ignored.
  - No timeout: the FSM waits indefinitely.
- IDLE:
  - rgb_led=001. Each cycle force score=0, lives_left=LIVES, cur_num=0, next_num=0, last_correct=0.
  - confirm rise -> DRAW_FIRST.
- DRAW_FIRST: on transfer, cur_num<=rnd_data -> GUESS.
- GUESS:
  - rgb_led=111.
  - higher rise alone -> latch guess=HI, go to DRAW_NEXT.
  - lower rise alone -> latch guess=LO, go to DRAW_NEXT.
  - Both rising in the same cycle -> ignored, stay in GUESS.
  - confirm is ignored.
- DRAW_NEXT: on transfer, next_num<=rnd_data -> CHECK.
- CHECK (exactly 1 cycle, unsigned compare):
  - Correct = (HI and next>cur) or (LO and next<cur), or a tie with TIE_MODE=1.
    - Effects: score<=score+1, saturating; last_correct<=1; rgb_led<=010.
  - Tie with TIE_MODE=2 (neutral): score and lives unchanged, last_correct<=1.
  - Miss (all other cases): last_correct<=0; rgb_led<=110.
    - If lives_left>1: lives_left-1.
    - Else: lives_left<=0 -> RESULT.
  - Every non-RESULT exit: cur_num<=next_num -> GUESS (GUESS re-drives 111 on the following cycle).
- RESULT:
  - rgb_led=100.
  - On the entry cycle, if score>high_score: high_score<=score and new_high=1 for that cycle only.
  - Equal score does not update high_score or pulse new_high.
  - confirm rise -> IDLE.
- Latency:
  - Guess rise at edge k -> DRAW_NEXT at k+1.
  - Transfer at edge m -> CHECK at m+1 -> GUESS/RESULT at m+2.
- Illegal state encodings (6, 7) -> IDLE on the next edge.

Test Plan:
1. Assert reset mid-DRAW_NEXT, then release -> state=0, rnd_req=0, rgb=000, lives_left=3, score=0, high_score=0. First IDLE cycle -> rgb=001.
2. Confirm pulse; supply 0x40 -> cur_num=0x40, state=2. Higher pulse; supply 0x80 two cycles later -> CHECK then GUESS, score=1, cur_num=0x80, last_correct=1.
3. LIVES=3, three wrong guesses (lower, draws higher each time) -> lives_left 2, 1, then 0 with state=5, rgb=100, high_score=score. new_high is high exactly one cycle if score>0.
4. cur=0x30, draw 0x30:
   - TIE_MODE=0 -> lives decremented.
   - TIE_MODE=1 -> score+1.
   - TIE_MODE=2 -> score and lives unchanged, cur_num=0x30, state=2.
5. Higher and lower rise in the same cycle -> state stays 2, rnd_req=0. Higher held for 20 cycles -> exactly one DRAW_NEXT.
6. SCORE_W=2, five correct guesses -> score 1, 2, 3, 3, 3. Second game scoring 3 against high_score=3 -> no new_high pulse.

Source files
------------

// File: rtl/higher_or_lower_game_ctrl.sv
// rtl/higher_or_lower_game_ctrl.sv - higher/lower game controller with lives, tie policy and high score
module higher_or_lower_game_ctrl #(
  parameter int NUM_W    = 8,
  parameter int SCORE_W  = 8,
  parameter int LIVES    = 3,
  parameter int TIE_MODE = 0,
  parameter int LIV_W    = $clog2(LIVES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               higher_btn,
  input  logic               lower_btn,
  input  logic               confirm_btn,
  input  logic [NUM_W-1:0]   rnd_data,
  input  logic               rnd_valid,
  output logic               rnd_req,
  output logic [2:0]         state,
  output logic [NUM_W-1:0]   cur_num,
  output logic [NUM_W-1:0]   next_num,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [LIV_W-1:0]   lives_left,
  output logic               last_correct,
  output logic               new_high,
  output logic [2:0]         rgb_led
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DRAW_FIRST = 3'd1,
    S_GUESS      = 3'd2,
    S_DRAW_NEXT  = 3'd3,
    S_CHECK      = 3'd4,
    S_RESULT     = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [NUM_W-1:0]   r_cur;
  logic [NUM_W-1:0]   r_next;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_high;
  logic [LIV_W-1:0]   r_lives;
  logic               r_last;
  logic [2:0]         r_rgb;
  logic               r_guess_hi;
  logic               r_hi_q;
  logic               r_lo_q;
  logic               r_cf_q;

  logic w_hi_rise;
  logic w_lo_rise;
  logic w_cf_rise;
  logic w_one_guess;
  logic w_eq;
  logic w_correct;
  logic w_neutral;
  logic w_miss;
  logic w_last_life;

  assign w_hi_rise   = higher_btn & ~r_hi_q;
  assign w_lo_rise   = lower_btn & ~r_lo_q;
  assign w_cf_rise   = confirm_btn & ~r_cf_q;
  // Simultaneous higher+lower rises cancel out and leave the guess pending.
  assign w_one_guess = w_hi_rise ^ w_lo_rise;

  assign w_eq        = (r_next == r_cur);
  assign w_correct   = (r_guess_hi & (r_next > r_cur)) | (~r_guess_hi & (r_next < r_cur)) |
                       (w_eq & (TIE_MODE == 1));
  assign w_neutral   = w_eq & (TIE_MODE == 2);
  assign w_miss      = ~w_correct & ~w_neutral;
  assign w_last_life = (r_lives <= LIV_W'(1));

  assign state        = r_state;
  assign cur_num      = r_cur;
  assign next_num     = r_next;
  assign score        = r_score;
  assign high_score   = r_high;
  assign lives_left   = r_lives;
  assign last_correct = r_last;
  assign rgb_led      = r_rgb;

  // Previous button levels for rise detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi_q <= 1'b0;
      r_lo_q <= 1'b0;
      r_cf_q <= 1'b0;
    end else begin
      r_hi_q <= higher_btn;
      r_lo_q <= lower_btn;
      r_cf_q <= confirm_btn;
    end
  end

  // Game state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode plus the random request and high-score pulse.
  always_comb begin
    w_next_state = r_state;
    rnd_req      = 1'b0;
    new_high     = 1'b0;
    case (r_state)
      S_IDLE:       if (w_cf_rise) w_next_state = S_DRAW_FIRST;
      S_DRAW_FIRST: begin
        rnd_req = 1'b1;
        if (rnd_valid) w_next_state = S_GUESS;
      end
      S_GUESS:      if (w_one_guess) w_next_state = S_DRAW_NEXT;
      S_DRAW_NEXT:  begin
        rnd_req = 1'b1;
        if (rnd_valid) w_next_state = S_CHECK;
      end
      S_CHECK:      w_next_state = (w_miss && w_last_life) ? S_RESULT : S_GUESS;
      S_RESULT:     begin
        // high_score catches up at the end of the entry cycle, so this is a single pulse.
        new_high = (r_score > r_high);
        if (w_cf_rise) w_next_state = S_IDLE;
      end
      default:      w_next_state = S_IDLE;
    endcase
  end

  // Game datapath: numbers, score, lives, LED colour and high score.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur      <= '0;
      r_next     <= '0;
      r_score    <= '0;
      r_high     <= '0;
      r_lives    <= LIV_W'(LIVES);
      r_last     <= 1'b0;
      r_rgb      <= 3'b000;
      r_guess_hi <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rgb   <= 3'b001;
          r_score <= '0;
          r_lives <= LIV_W'(LIVES);
          r_cur   <= '0;
          r_next  <= '0;
          r_last  <= 1'b0;
        end
        S_DRAW_FIRST: if (rnd_valid) r_cur <= rnd_data;
        S_GUESS: begin
          r_rgb <= 3'b111;
          if (w_one_guess) r_guess_hi <= w_hi_rise;
        end
        S_DRAW_NEXT: if (rnd_valid) r_next <= rnd_data;
        S_CHECK: begin
          if (w_correct) begin
            if (!(&r_score)) r_score <= r_score + SCORE_W'(1);
            r_last <= 1'b1;
            r_rgb  <= 3'b010;
            r_cur  <= r_next;
          end else if (w_neutral) begin
            r_last <= 1'b1;
            r_cur  <= r_next;
          end else begin
            r_last <= 1'b0;
            r_rgb  <= 3'b110;
            if (!w_last_life) begin
              r_lives <= r_lives - LIV_W'(1);
              r_cur   <= r_next;
            end else begin
              r_lives <= '0;
            end
          end
        end
        S_RESULT: begin
          r_rgb <= 3'b100;
          if (r_score > r_high) r_high <= r_score;
        end
        default: ;
      endcase
    end
  end

endmodule
